// File: rtl/inst_fetch_bridge.sv
// rtl/inst_fetch_bridge.sv - fetches a bundle of instructions one memory beat at a time.
// At most one memory read is in flight; flushes abandon the bundle and drain a pending response.
module inst_fetch_bridge #(
    parameter int FETCH_WIDTH      = 4,
    parameter int SIZE_PC          = 32,
    parameter int SIZE_INSTRUCTION = 32
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         resetFetch_i,
    input  logic                                         recoverFlag_i,
    input  logic                                         exceptionFlag_i,
    input  logic                                         fetchReq_i,
    input  logic [FETCH_WIDTH-1:0][SIZE_PC-1:0]          instPC_i,
    output logic [FETCH_WIDTH-1:0][SIZE_INSTRUCTION-1:0] inst_o,
    output logic                                         instValid_o,
    output logic                                         fetchBusy_o,
    output logic                                         memReqValid_o,
    output logic [SIZE_PC-1:0]                           memReqAddr_o,
    input  logic                                         memReqReady_i,
    input  logic                                         memRespValid_i,
    input  logic [SIZE_INSTRUCTION-1:0]                  memRespData_i
);

    localparam int BEAT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FETCH_WIDTH - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t                                       state_q, state_d;
    logic [BEAT_W-1:0]                            beat_q, beat_d;
    logic [FETCH_WIDTH-1:0][SIZE_PC-1:0]          pc_q;
    logic [FETCH_WIDTH-1:0][SIZE_INSTRUCTION-1:0] buf_q;
    logic [FETCH_WIDTH-1:0][SIZE_INSTRUCTION-1:0] inst_q;
    logic                                         flush;
    logic                                         req_fire;
    logic                                         latch_pc;
    logic                                         store_resp;

    assign flush    = resetFetch_i | recoverFlag_i | exceptionFlag_i;
    assign req_fire = (state_q == S_REQ) && memReqReady_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            pc_q    <= '0;
            buf_q   <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (latch_pc) begin
                pc_q <= instPC_i;
            end
            if (store_resp) begin
                buf_q[beat_q] <= memRespData_i;
            end
            if (state_q == S_DONE) begin
                inst_q <= buf_q;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        latch_pc      = 1'b0;
        store_resp    = 1'b0;
        instValid_o   = 1'b0;
        memReqValid_o = 1'b0;
        memReqAddr_o  = '0;
        fetchBusy_o   = (state_q != S_IDLE);
        inst_o        = inst_q;
        case (state_q)
            S_IDLE: begin
                if (fetchReq_i && !flush) begin
                    latch_pc = 1'b1;
                    beat_d   = '0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                memReqValid_o = 1'b1;
                memReqAddr_o  = pc_q[beat_q];
                // A request that handshook during the flush still owes us a response.
                if (flush) begin
                    state_d = req_fire ? S_DRAIN : S_IDLE;
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = memRespValid_i ? S_IDLE : S_DRAIN;
                end else if (memRespValid_i) begin
                    store_resp = 1'b1;
                    if (beat_q == BEAT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d  = beat_q + BEAT_ONE;
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                instValid_o = !flush;
                inst_o      = buf_q;
                state_d     = S_IDLE;
            end
            S_DRAIN: begin
                if (memRespValid_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb/tb_inst_fetch_bridge.sv - scoreboard bench for inst_fetch_bridge with a reactive memory model.
module tb_inst_fetch_bridge;

    localparam int FW = 4;
    typedef logic [FW-1:0][31:0] bundle_t;

    logic           clk;
    logic           reset;
    logic           resetFetch_i, recoverFlag_i, exceptionFlag_i, fetchReq_i;
    bundle_t        instPC_i;
    bundle_t        inst_o;
    logic           instValid_o, fetchBusy_o, memReqValid_o;
    logic [31:0]    memReqAddr_o;
    logic           memReqReady_i, memRespValid_i;
    logic [31:0]    memRespData_i;

    inst_fetch_bridge #(.FETCH_WIDTH(FW), .SIZE_PC(32), .SIZE_INSTRUCTION(32)) dut (
        .clk(clk), .reset(reset),
        .resetFetch_i(resetFetch_i), .recoverFlag_i(recoverFlag_i), .exceptionFlag_i(exceptionFlag_i),
        .fetchReq_i(fetchReq_i), .instPC_i(instPC_i),
        .inst_o(inst_o), .instValid_o(instValid_o), .fetchBusy_o(fetchBusy_o),
        .memReqValid_o(memReqValid_o), .memReqAddr_o(memReqAddr_o), .memReqReady_i(memReqReady_i),
        .memRespValid_i(memRespValid_i), .memRespData_i(memRespData_i)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bundle_t     exp_q[$];
    logic [31:0] exp_addr_q[$];
    bundle_t     mon_b;
    int          valid_count = 0;
    int          last_valid_cyc = 0;
    int          accept_cyc = 0;

    // memory model controls
    int          hs_count = 0;
    int          outstanding = 0;
    bit          pending = 0;
    int          pend_delay = 0;
    logic [31:0] pend_data = '0;
    int          rdy_mode = 0;
    int          fixed_delay = 0;
    int          resp_delay_max = 3;
    int          stall_left = 0;
    int          stall_beat = 0;
    bit          hold_ready_low = 0;
    logic [31:0] data_xor = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // memory slave: data returned is address ^ data_xor, in order, one at a time
    initial begin
        memReqReady_i = 1'b0;
        memRespValid_i = 1'b0;
        memRespData_i = '0;
        forever begin
            @(negedge clk);
            if (!reset && memReqValid_o && memReqReady_i) begin
                check("one_outstanding", outstanding, 0);
                outstanding++;
                hs_count++;
                pending    = 1;
                pend_data  = memReqAddr_o ^ data_xor;
                pend_delay = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, resp_delay_max);
            end
            @(posedge clk); #1;
            memRespValid_i = 1'b0;
            if (pending) begin
                if (pend_delay == 0) begin
                    memRespValid_i = 1'b1;
                    memRespData_i  = pend_data;
                    pending        = 0;
                    outstanding--;
                end else begin
                    pend_delay--;
                end
            end
            if (stall_left > 0 && hs_count == stall_beat && memReqValid_o) begin
                memReqReady_i = 1'b0;
                stall_left--;
            end else if (hold_ready_low) begin
                memReqReady_i = 1'b0;
            end else if (rdy_mode == 1) begin
                memReqReady_i = ($urandom_range(0, 3) != 0);
            end else begin
                memReqReady_i = 1'b1;
            end
        end
    end

    // request address monitor
    always @(negedge clk) begin
        if (!reset && memReqValid_o) begin
            if (exp_addr_q.size() == 0) begin
                check("req_expected", exp_addr_q.size() != 0, 1);
            end else begin
                check("req_addr", memReqAddr_o, exp_addr_q[0]);
                if (memReqReady_i) void'(exp_addr_q.pop_front());
            end
        end
    end

    // bundle monitor
    always @(negedge clk) begin
        if (!reset && instValid_o) begin
            last_valid_cyc = cyc;
            valid_count++;
            if (exp_q.size() == 0) begin
                check("valid_expected", exp_q.size() != 0, 1);
            end else begin
                mon_b = exp_q.pop_front();
                check("bundle", inst_o, mon_b);
            end
        end
    end

    task automatic push_txn(input bundle_t pcs, input bit expect_bundle);
        bundle_t eb;
        for (int i = 0; i < FW; i++) begin
            exp_addr_q.push_back(pcs[i]);
            eb[i] = pcs[i] ^ data_xor;
        end
        if (expect_bundle) exp_q.push_back(eb);
    endtask

    task automatic start_fetch(input bundle_t pcs, input bit expect_bundle);
        push_txn(pcs, expect_bundle);
        hs_count = 0;
        @(posedge clk); #1;
        instPC_i   = pcs;
        fetchReq_i = 1'b1;
        accept_cyc = cyc;
        @(posedge clk); #1;
        fetchReq_i = 1'b0;
    endtask

    task automatic wait_valid(input int vc0, input int limit);
        int n = 0;
        while (valid_count == vc0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("valid_arrived", valid_count != vc0, 1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((fetchBusy_o || pending) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("returns_idle", fetchBusy_o | pending, 0);
    endtask

    task automatic wait_hs(input int k, input int limit);
        int n = 0;
        while (hs_count < k && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("handshake_count", hs_count, k);
    endtask

    initial begin
        bundle_t pcs;
        int      vc, v1, n, k, src;
        reset = 1'b1;
        resetFetch_i = 0; recoverFlag_i = 0; exceptionFlag_i = 0; fetchReq_i = 0;
        instPC_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", instValid_o, 0);
        check("rst_reqvalid", memReqValid_o, 0);
        check("rst_busy", fetchBusy_o, 0);
        check("rst_addr", memReqAddr_o, 0);
        check("rst_inst", inst_o, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // zero-wait bundle, data = addr
        pcs = {32'h10C, 32'h108, 32'h104, 32'h100};
        vc = valid_count;
        start_fetch(pcs, 1);
        wait_valid(vc, 40);
        check("latency_zero_wait", last_valid_cyc - accept_cyc, 9);
        wait_idle(20);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("inst_hold", inst_o, pcs);

        // ready low 3 cycles on beat 2
        stall_beat = 2;
        stall_left = 3;
        vc = valid_count;
        start_fetch(pcs, 1);
        wait_valid(vc, 40);
        check("latency_stall", last_valid_cyc - accept_cyc, 12);
        check("stall_consumed", stall_left, 0);
        wait_idle(20);

        // flush in IDLE suppresses acceptance
        @(posedge clk); #1;
        fetchReq_i = 1; resetFetch_i = 1; instPC_i = pcs;
        @(posedge clk); #1;
        fetchReq_i = 0; resetFetch_i = 0;
        @(negedge clk);
        check("idle_flush_busy", fetchBusy_o, 0);
        check("idle_flush_req", memReqValid_o, 0);

        // recover flush in WAIT of beat 1, response still outstanding
        fixed_delay = 2;
        vc = valid_count;
        start_fetch(pcs, 0);
        wait_hs(2, 30);
        recoverFlag_i = 1;
        exp_addr_q.delete();
        @(posedge clk); #1;
        recoverFlag_i = 0;
        @(negedge clk);
        check("drain_busy", fetchBusy_o, 1);
        wait_idle(20);
        repeat (3) @(posedge clk); #1;
        check("drain_no_new_req", hs_count, 2);
        check("drain_no_valid", valid_count, vc);
        fixed_delay = 0;

        // exception in DONE
        vc = valid_count;
        start_fetch(pcs, 0);
        repeat (8) begin @(posedge clk); #1; end
        exceptionFlag_i = 1;
        @(negedge clk);
        check("done_exc_valid", instValid_o, 0);
        check("done_exc_busy", fetchBusy_o, 1);
        @(posedge clk); #1;
        exceptionFlag_i = 0;
        @(negedge clk);
        check("done_exc_idle", fetchBusy_o, 0);
        check("done_exc_count", valid_count, vc);

        // fetchReq held high: no acceptance in DONE
        pcs = {32'h20C, 32'h208, 32'h204, 32'h200};
        push_txn(pcs, 1);
        push_txn(pcs, 1);
        hs_count = 0;
        vc = valid_count;
        @(posedge clk); #1;
        instPC_i = pcs; fetchReq_i = 1; accept_cyc = cyc;
        wait_valid(vc, 40);
        v1 = last_valid_cyc;
        check("held_latency", v1 - accept_cyc, 9);
        n = 0;
        while (!memReqValid_o && n < 10) begin @(posedge clk); #1; n++; end
        check("held_next_req_gap", cyc - v1, 2);
        @(posedge clk); #1;
        fetchReq_i = 0;
        wait_valid(vc + 1, 40);
        check("held_second_gap", last_valid_cyc - v1, 10);
        wait_idle(20);

        // randomized traffic with random stalls, delays and flushes
        data_xor = $urandom;
        rdy_mode = 1;
        fixed_delay = -1;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < FW; i++) pcs[i] = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, FW);
                src = $urandom_range(0, 2);
                start_fetch(pcs, 0);
                wait_hs(k, 100);
                resetFetch_i    = (src == 0);
                recoverFlag_i   = (src == 1);
                exceptionFlag_i = (src == 2);
                exp_addr_q.delete();
                @(posedge clk); #1;
                resetFetch_i = 0; recoverFlag_i = 0; exceptionFlag_i = 0;
            end else begin
                vc = valid_count;
                start_fetch(pcs, 1);
                wait_valid(vc, 200);
            end
            wait_idle(200);
        end

        // asynchronous reset while a request is held in REQ
        rdy_mode = 0;
        fixed_delay = 0;
        hold_ready_low = 1;
        start_fetch(pcs, 0);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("async_rst_reqvalid", memReqValid_o, 0);
        check("async_rst_busy", fetchBusy_o, 0);
        check("async_rst_valid", instValid_o, 0);
        check("async_rst_addr", memReqAddr_o, 0);
        check("async_rst_inst", inst_o, 0);
        exp_addr_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        hold_ready_low = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_rst_idle", fetchBusy_o, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_bridge.md
INST_FETCH_BRIDGE -- requirements
Module: inst_fetch_bridge

Interface
REQ-001 Parameter FETCH_WIDTH, default 4, SHALL set the instructions per fetch bundle; legal range 1..8.
REQ-002 Parameter SIZE_PC, default 32, SHALL set the PC width in bits.
REQ-003 Parameter SIZE_INSTRUCTION, default 32, SHALL set the instruction width in bits.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 resetFetch_i  in  1  SHALL be a synchronous fetch flush.
REQ-007 recoverFlag_i  in  1  SHALL be a synchronous flush caused by branch recovery.
REQ-008 exceptionFlag_i  in  1  SHALL be a synchronous flush caused by an exception.
REQ-009 fetchReq_i  in  1  SHALL request a bundle from fetch stage 1.
REQ-010 instPC_i  in  FETCH_WIDTH x SIZE_PC  SHALL carry the per-lane instruction PCs.
REQ-011 inst_o  out  FETCH_WIDTH x SIZE_INSTRUCTION  SHALL carry the assembled bundle.
REQ-012 instValid_o  out  1  SHALL mark inst_o valid for one cycle.
REQ-013 fetchBusy_o  out  1  SHALL be high whenever the FSM is not IDLE.
REQ-014 memReqValid_o  out  1  SHALL be the memory read request valid.
REQ-015 memReqAddr_o  out  SIZE_PC  SHALL be the memory read address.
REQ-016 memReqReady_i  in  1  SHALL be the memory ready; the request transfers when valid and ready are both high.
REQ-017 memRespValid_i  in  1  SHALL mark a response beat; responses return in order.
REQ-018 memRespData_i  in  SIZE_INSTRUCTION  SHALL carry the response data.

Function
REQ-019 flush SHALL be defined as resetFetch_i | recoverFlag_i | exceptionFlag_i.
REQ-020 The FSM SHALL have exactly five states: IDLE, REQ, WAIT, DONE and DRAIN.
REQ-021 In IDLE with fetchReq_i=1 and flush=0, the block SHALL latch all instPC_i lanes, clear the beat counter to 0 and go to REQ.
REQ-022 In REQ, memReqValid_o SHALL be 1 and memReqAddr_o SHALL equal the latched PC of lane[beat]; on handshake the FSM SHALL go to WAIT, otherwise it SHALL hold REQ with a stable address.
REQ-023 At most one memory request SHALL be outstanding at any time.
REQ-024 In WAIT, on memRespValid_i the block SHALL store memRespData_i into lane[beat]; if beat==FETCH_WIDTH-1 it SHALL go to DONE, else it SHALL increment beat and go to REQ.
REQ-025 In DONE, instValid_o SHALL equal !flush and the FSM SHALL return to IDLE unconditionally.
REQ-026 A new request SHALL NOT be accepted in DONE; the earliest acceptance is in the following IDLE cycle.
REQ-027 inst_o SHALL hold its last value outside DONE; lanes are undefined for consumers unless instValid_o=1.
REQ-028 Flush in IDLE SHALL suppress acceptance of fetchReq_i.
REQ-029 Flush in REQ, whether or not the handshake occurs, SHALL send the FSM to DRAIN if the handshake occurred, else to IDLE; memReqValid_o SHALL remain asserted during that cycle.
REQ-030 Flush in WAIT SHALL send the FSM to DRAIN if memRespValid_i=0, or to IDLE if memRespValid_i=1 (that response is discarded).
REQ-031 In DRAIN, the next memRespValid_i SHALL be discarded and the FSM SHALL go to IDLE; a flush during DRAIN SHALL have no further effect.
REQ-032 Latency with zero-wait memory (ready=1, response one cycle after the handshake) SHALL be 2*FETCH_WIDTH+1 cycles from fetchReq_i acceptance to instValid_o; this is 9 cycles for FETCH_WIDTH=4.
REQ-033 The beat counter SHALL be $clog2(FETCH_WIDTH) bits wide, minimum 1 bit, and SHALL never exceed FETCH_WIDTH-1.

Reset
REQ-034 While reset=1, the FSM SHALL be IDLE and the beat counter 0.
REQ-035 While reset=1, instValid_o, memReqValid_o and fetchBusy_o SHALL be 0, and memReqAddr_o and all inst_o lanes SHALL be 0.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction without draining; any memory response arriving after reset SHALL be ignored.

Verification
REQ-037 Scenario: FETCH_WIDTH=4, PCs 0x100/0x104/0x108/0x10C, zero-wait memory returning data=addr -> memReqAddr_o sequence is 0x100, 0x104, 0x108, 0x10C; instValid_o=1 nine cycles after acceptance with inst_o={0x100,0x104,0x108,0x10C}.
REQ-038 Scenario: memReqReady_i held low for 3 cycles on beat 2 -> memReqValid_o stays high with a stable address of 0x108; instValid_o is delayed by exactly 3 cycles.
REQ-039 Scenario: recoverFlag_i pulsed in WAIT of beat 1 with no response present -> FSM enters DRAIN, the next response is discarded, FSM returns to IDLE, and no instValid_o is produced.
REQ-040 Scenario: exceptionFlag_i asserted in the DONE cycle -> instValid_o=0 and FSM returns to IDLE.
REQ-041 Scenario: fetchReq_i held high continuously -> no acceptance occurs in DONE; the next request issues 2 cycles after instValid_o, and the number of outstanding requests never exceeds 1.
REQ-042 Scenario: reset asserted asynchronously mid-REQ -> memReqValid_o and fetchBusy_o drop without waiting for a clock edge, and all outputs read 0.
